// File: rtl/ascii_scroll_buffer.sv
// ascii_scroll_buffer: character scroll/fill buffer with echo handshake and multiplexed digit scan
module ascii_scroll_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SCAN_DIV = 125000,
  parameter logic [DATA_WIDTH-1:0] BLANK_CODE = DATA_WIDTH'(8'h00),
  localparam int CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  mode,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] digit_code,
  output logic [NUM_DIGITS-1:0] an,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  overflow
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  typedef enum logic [1:0] {IDLE, WAIT, START} echo_t;
  logic [DATA_WIDTH-1:0] slot_q [NUM_DIGITS];
  logic [DATA_WIDTH-1:0] slot_d [NUM_DIGITS];
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, txs_q, txs_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  echo_t state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic is_bs, is_cr, is_esc, printable, reject;
  assign is_bs = rx_data == DATA_WIDTH'(8'h08);
  assign is_cr = rx_data == DATA_WIDTH'(8'h0D);
  assign is_esc = rx_data == DATA_WIDTH'(8'h1B);
  assign printable = !(is_bs || is_cr || is_esc);
  assign reject = printable && mode && full;
  assign full = count_q == CW'(NUM_DIGITS);
  assign count = count_q;
  assign overflow = ovf_q;
  assign tx_data = txd_q;
  assign tx_start = txs_q;
  assign an = ~(NUM_DIGITS'(1) << idx_q);
  assign digit_code = slot_q[idx_q];
  // Buffer edits and echo handshake; a character arriving mid-echo still edits the buffer
  always_comb begin
    slot_d = slot_q;
    count_d = count_q;
    ovf_d = ovf_q;
    txd_d = txd_q;
    txs_d = 1'b0;
    state_d = state_q == START ? IDLE : state_q;
    if (state_q == WAIT && !tx_busy) begin
      state_d = START;
      txs_d = 1'b1;
    end
    if (rx_valid) begin
      if (printable && !mode) begin
        slot_d[0] = rx_data;
        for (int i = 1; i < NUM_DIGITS; i++) slot_d[i] = slot_q[i-1];
        count_d = full ? count_q : count_q + CW'(1);
      end
      if (printable && mode && !full) begin
        for (int i = 0; i < NUM_DIGITS; i++) if (i == NUM_DIGITS - 1 - int'(count_q)) slot_d[i] = rx_data;
        count_d = count_q + CW'(1);
      end
      if (is_bs && count_q != '0) begin
        if (!mode) begin
          for (int i = 0; i < NUM_DIGITS - 1; i++) slot_d[i] = slot_q[i+1];
          slot_d[NUM_DIGITS-1] = BLANK_CODE;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) if (i == NUM_DIGITS - int'(count_q)) slot_d[i] = BLANK_CODE;
        end
        count_d = count_q - CW'(1);
      end
      if (is_cr || is_esc) begin
        for (int i = 0; i < NUM_DIGITS; i++) slot_d[i] = BLANK_CODE;
        count_d = '0;
      end
      if (state_q != IDLE || reject) ovf_d = 1'b1;
      else begin
        state_d = WAIT;
        txd_d = rx_data;
      end
      if (is_esc) ovf_d = 1'b0;
    end
  end
  // Scan divider: hold each digit for SCAN_DIV clocks, then advance round-robin
  always_comb begin
    cnt_d = cnt_q == SW'(SCAN_DIV - 1) ? '0 : cnt_q + SW'(1);
    idx_d = cnt_q != SW'(SCAN_DIV - 1) ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
  end
  // State registers; reset wins over any simultaneous character or echo
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= BLANK_CODE;
      count_q <= '0;
      ovf_q <= 1'b0;
      txd_q <= '0;
      txs_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      slot_q <= slot_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      txd_q <= txd_d;
      txs_q <= txs_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_ascii_scroll_buffer.sv
// tb_ascii_scroll_buffer: directed and random checks against a behavioural display model
module tb_ascii_scroll_buffer;
  localparam int N = 4;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic mode = 1'b0;
  logic tx_busy = 1'b0;
  logic [7:0] tx_data, digit_code;
  logic tx_start, full, overflow;
  logic [N-1:0] an;
  logic [2:0] count;
  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;
  logic [7:0] last_tx = '0;
  logic [7:0] obs [N];
  logic [7:0] ms [N];
  int mc = 0;
  bit movf = 0;
  int ph = 0;
  logic [7:0] mtxd = '0;
  int sc = 0;

  ascii_scroll_buffer #(.NUM_DIGITS(N), .DATA_WIDTH(8), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .mode(mode),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .digit_code(digit_code),
    .an(an), .count(count), .full(full), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Display model: slot 0 is the rightmost digit; echo walks idle -> waiting -> pulsing
  task automatic model_edge();
    int old;
    bit rej;
    if (reset) begin
      foreach (ms[i]) ms[i] = 8'h00;
      mc = 0; movf = 0; ph = 0; mtxd = 8'h00; sc = 0;
    end else begin
      old = ph;
      rej = 0;
      sc = (sc + 1) % (SD * N);
      if (old == 1 && !tx_busy) ph = 2;
      else if (old == 2) ph = 0;
      if (rx_valid) begin
        case (rx_data)
          8'h08: if (mc > 0) begin
            if (!mode) begin
              for (int i = 0; i < N - 1; i++) ms[i] = ms[i+1];
              ms[N-1] = 8'h00;
            end else ms[N-mc] = 8'h00;
            mc--;
          end
          8'h0D, 8'h1B: begin
            foreach (ms[i]) ms[i] = 8'h00;
            mc = 0;
          end
          default: if (!mode) begin
            for (int i = N - 1; i > 0; i--) ms[i] = ms[i-1];
            ms[0] = rx_data;
            if (mc < N) mc++;
          end else if (mc < N) begin
            ms[N-1-mc] = rx_data;
            mc++;
          end else rej = 1;
        endcase
        if (old != 0 || rej) movf = 1;
        else begin
          mtxd = rx_data;
          ph = 1;
        end
        if (rx_data == 8'h1B) movf = 0;
      end
    end
  endtask

  task automatic tick();
    int idx;
    logic [N-1:0] ea;
    @(posedge clk);
    model_edge();
    #1;
    idx = sc / SD;
    ea = '1;
    ea[idx] = 1'b0;
    chk("count", 32'(count), 32'(mc));
    chk("full", 32'(full), 32'(mc == N));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("tx_start", 32'(tx_start), 32'(ph == 2));
    chk("tx_data", 32'(tx_data), 32'(mtxd));
    chk("an", 32'(an), 32'(ea));
    chk("digit_code", 32'(digit_code), 32'(ms[idx]));
    if (tx_start === 1'b1) begin
      pulses++;
      last_tx = tx_data;
    end
  endtask

  task automatic send(input logic [7:0] c);
    rx_data = c;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic scan_read();
    foreach (obs[i]) obs[i] = 8'hxx;
    repeat (SD * N) begin
      tick();
      for (int i = 0; i < N; i++) if (an[i] === 1'b0) obs[i] = digit_code;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    tx_busy = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    pulses = 0;
  endtask

  initial begin
    string s;
    logic [7:0] r;
    repeat (2) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    mode = 1'b0;
    s = "ABCDE";
    for (int i = 0; i < 5; i++) send(s[i]);
    scan_read();
    chk("shift_slots", {obs[3], obs[2], obs[1], obs[0]}, {"B", "C", "D", "E"});
    chk("shift_count", 32'(count), 4);
    chk("shift_full", 32'(full), 1);
    chk("shift_pulses", pulses, 5);
    chk("shift_last_tx", 32'(last_tx), 32'("E"));
    do_reset();
    mode = 1'b1;
    s = "WXYZQ";
    for (int i = 0; i < 5; i++) send(s[i]);
    scan_read();
    chk("fill_slots", {obs[3], obs[2], obs[1], obs[0]}, {"W", "X", "Y", "Z"});
    chk("fill_overflow", 32'(overflow), 1);
    chk("fill_pulses", pulses, 4);
    chk("fill_last_tx", 32'(last_tx), 32'("Z"));
    do_reset();
    mode = 1'b0;
    send("A");
    send("B");
    send(8'h08);
    scan_read();
    chk("bs_slots", {obs[3], obs[2], obs[1], obs[0]}, {8'h00, 8'h00, 8'h00, "A"});
    chk("bs_count", 32'(count), 1);
    send(8'h08);
    pulses = 0;
    send(8'h08);
    chk("bs_empty_count", 32'(count), 0);
    chk("bs_empty_echo", pulses, 1);
    chk("bs_empty_overflow", 32'(overflow), 0);
    do_reset();
    tx_busy = 1'b1;
    send("M");
    send("N");
    repeat (42) tick();
    chk("busy_no_pulse", pulses, 0);
    chk("busy_overflow", 32'(overflow), 1);
    tx_busy = 1'b0;
    repeat (4) tick();
    chk("busy_pulses", pulses, 1);
    chk("busy_tx_data", 32'(last_tx), 32'("M"));
    send(8'h1B);
    chk("esc_overflow", 32'(overflow), 0);
    scan_read();
    chk("esc_slots", {obs[3], obs[2], obs[1], obs[0]}, 0);
    do_reset();
    tx_busy = 1'b1;
    rx_data = "R";
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("abort_an", 32'(an), 32'(4'b1110));
    chk("abort_tx_start", 32'(tx_start), 0);
    reset = 1'b0;
    tx_busy = 1'b0;
    repeat (10) tick();
    chk("abort_pulses", pulses, 0);
    repeat (3000) begin
      r = 8'($urandom_range(0, 7));
      rx_valid = $urandom_range(0, 2) == 0;
      rx_data = r == 0 ? 8'h08 : r == 1 ? 8'h0D : (r == 2 && $urandom_range(0, 3) == 0) ? 8'h1B : 8'($urandom_range(32, 126));
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      tx_busy = $urandom_range(0, 3) == 0;
      reset = $urandom_range(0, 299) == 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ascii_scroll_buffer.md
ASCII_SCROLL_BUFFER -- requirements
Module: ascii_scroll_buffer

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of display digit slots, 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: bits per stored character.
REQ-003 Parameter SCAN_DIV, default 125000: clk cycles each digit is driven per scan step, >=2.
REQ-004 Parameter BLANK_CODE, default 8'h00: code written to empty slots, which the decoder renders dark.
REQ-005 clk  input  1  system clock; one clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 rx_data  input  DATA_WIDTH  received character, valid only while rx_valid=1.
REQ-008 rx_valid  input  1  single-cycle strobe, one character per high cycle.
REQ-009 mode  input  1  0=SHIFT (newest at digit 0, older move left), 1=FILL (write left-to-right at cursor).
REQ-010 tx_busy  input  1  echo transmitter busy.
REQ-011 tx_data  output  DATA_WIDTH  echo character.
REQ-012 tx_start  output  1  single-cycle echo request.
REQ-013 digit_code  output  DATA_WIDTH  character of the currently scanned slot, to the decoder.
REQ-014 an  output  NUM_DIGITS  active-low one-hot digit enable.
REQ-015 count  output  clog2(NUM_DIGITS+1)  number of occupied slots.
REQ-016 full  output  1  count==NUM_DIGITS.
REQ-017 overflow  output  1  sticky flag: echo dropped or FILL write rejected.

Function
REQ-018 Control codes are 8'h08 (BS), 8'h0D (CR) and 8'h1B (ESC); every other code is printable.
REQ-019 SHIFT, printable: slot[i+1]<=slot[i], slot[0]<=rx_data, old slot[N-1] discarded, count saturates at N, write visible next cycle.
REQ-020 FILL, printable, not full: slot[N-1-count]<=rx_data, count+1.
REQ-021 FILL, printable, full: slots unchanged, overflow<=1, no echo.
REQ-022 BS in SHIFT: slot[i]<=slot[i+1], slot[N-1]<=BLANK_CODE, count-1.
REQ-023 BS in FILL: slot[N-count]<=BLANK_CODE, count-1.
REQ-024 BS with count==0: no change, echo still issued.
REQ-025 CR: all slots<=BLANK_CODE, count<=0.
REQ-026 ESC: all slots<=BLANK_CODE, count<=0, overflow<=0.
REQ-027 A mode change takes effect on the next rx_valid; stored slots are not reordered.
REQ-028 Echo FSM states are IDLE, WAIT, START.
REQ-029 Echo, accepted character: latch it, IDLE->WAIT.
REQ-030 Echo in WAIT: when tx_busy==0, go to START.
REQ-031 Echo in START: tx_start=1 for exactly one cycle with tx_data=latched character, then IDLE.
REQ-032 Echo, rx_valid while the FSM is not IDLE: buffer still updates, echo dropped, overflow<=1.
REQ-033 Scan: counter 0..SCAN_DIV-1; at wrap, index increments modulo NUM_DIGITS (N-1 -> 0).
REQ-034 Scan: an[index]=0, all other bits 1; digit_code=slot[index], combinational from current slots.
REQ-035 rx_valid in the same cycle as a scan wrap: both take effect; no lost character, no glitch beyond that one-cycle update.

Reset
REQ-036 When reset is high at a clk edge: all slots=BLANK_CODE, count=0, full=0, overflow=0.
REQ-037 When reset is high at a clk edge: echo FSM=IDLE, tx_start=0, tx_data=0.
REQ-038 When reset is high at a clk edge: scan counter=0, index=0, an=~1 (digit 0 active).
REQ-039 Reset overrides a simultaneous rx_valid.
REQ-040 Reset during START or WAIT aborts the echo with no tx_start pulse.

Verification
REQ-041 N=4, SHIFT, send "ABCDE" -> slots[3:0]="BCDE", count=4, full=1, five tx_start pulses with tx_data matching each character.
REQ-042 N=4, FILL, send "WXYZQ" -> slots[3:0]="WXYZ", 'Q' rejected, overflow=1, four echoes only.
REQ-043 SHIFT "AB" then BS -> slot0='A', slots1..3 blank, count=1; BS at count=0 -> unchanged.
REQ-044 tx_busy held 1 for 50 cycles, two rx_valid strobes 3 cycles apart -> first echo issued after tx_busy falls, second dropped, overflow=1; then ESC -> overflow=0, all slots blank.
REQ-045 SCAN_DIV=4, N=4 -> an cycles 1110,1101,1011,0111 every 4 clks, digit_code tracks the slot; reset asserted mid-WAIT -> no tx_start, an=1110.
